// File: rtl/sipo_pkg.sv
// Shared types and sizing helpers for the sipo_deser serial-to-parallel block.
// Build option: define SIPO_PARITY_EN to append one even-parity bit to every word.
package sipo_pkg;

  // Output-side FSM: FILL accepts bits, STALL holds a finished word in the shift register.
  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  // Bit-counter width; sized so a parity slot always fits.
  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width + 2);
  endfunction

  // Bits per frame on the serial side.
  function automatic int unsigned frame_len(input int unsigned width);
`ifdef SIPO_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/sipo_bit_cnt.sv
// Modulo-MODULUS up-counter with increment, synchronous clear and terminal-count flag.
module sipo_bit_cnt #(
  parameter int unsigned MODULUS = 4,
  parameter int unsigned CNT_W   = 3
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  assign tc = (cnt == CNT_W'(MODULUS - 1));

  // Count accepted bits; wrap to zero after the last slot of a frame.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= tc ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in / parallel-out deserialiser, LSB first, with a shift register and an output
// holding register so the next word can fill while the current one waits downstream.
// Build option: SIPO_PARITY_EN adds an even-parity bit per word; bad words are dropped
// and flagged on par_err. Without it par_err is tied low.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             si,
  input  logic             si_valid,
  output logic             si_ready,
  output logic [WIDTH-1:0] po,
  output logic             po_valid,
  input  logic             po_ready,
  output logic             par_err
);

  localparam int unsigned CNT_W     = cnt_w(WIDTH);
  localparam int unsigned FRAME_LEN = frame_len(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [WIDTH-1:0]   po_q, po_d;
  logic               po_valid_q, po_valid_d;
  logic [CNT_W-1:0]   cnt;
  logic               tc;
  logic               accept;
  logic               consume;
  logic               shift_en;
  logic               par_bad;
  logic [WIDTH-1:0]   sr_shift;
  logic [WIDTH-1:0]   word;

  assign si_ready = (state_q == ST_FILL);
  assign accept   = si_valid & si_ready;
  assign consume  = po_valid_q & po_ready;
  assign sr_shift = {si, sr_q[WIDTH-1:1]};
  assign po       = po_q;
  assign po_valid = po_valid_q;

`ifdef SIPO_PARITY_EN
  // The parity bit is not shifted in; the data word is already complete in sr.
  assign shift_en = accept & ~tc;
  assign word     = sr_q;
  assign par_bad  = ^{sr_q, si};
`else
  // The final data bit joins the word on the same edge it is accepted.
  assign shift_en = accept;
  assign word     = sr_shift;
  assign par_bad  = 1'b0;
`endif

  sipo_bit_cnt #(
    .MODULUS (FRAME_LEN),
    .CNT_W   (CNT_W)
  ) u_bit_cnt (
    .clk   (clk),
    .clear (clear),
    .inc   (accept),
    .clr   (1'b0),
    .cnt   (cnt),
    .tc    (tc)
  );

  // Next-state: shift accepted bits, hand finished words to po or park them in STALL.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    po_d       = po_q;
    po_valid_d = po_valid_q;

    if (shift_en) sr_d = sr_shift;
    if (consume) po_valid_d = 1'b0;

    unique case (state_q)
      ST_FILL: begin
        if (accept && tc && !par_bad) begin
          if (!po_valid_q || po_ready) begin
            po_d       = word;
            po_valid_d = 1'b1;
          end else begin
            state_d = ST_STALL;
          end
        end
      end
      ST_STALL: begin
        // po_valid is necessarily set here, so po_ready is a real consume.
        if (po_ready) begin
          po_d       = sr_q;
          po_valid_d = 1'b1;
          state_d    = ST_FILL;
        end
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q    <= ST_FILL;
      sr_q       <= '0;
      po_q       <= '0;
      po_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      po_q       <= po_d;
      po_valid_q <= po_valid_d;
    end
  end

`ifdef SIPO_PARITY_EN
  logic par_err_q;

  // One-cycle pulse when a frame with bad parity is dropped.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= accept & tc & par_bad;
    end
  end

  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

endmodule
